// File: rtl/conv_controller_param.sv
// rtl/conv_controller_param.sv - control FSM for a KERNEL x KERNEL streaming convolution datapath
// Sequences coefficient load, column fill, multi-cycle convolve, streaming shift and row/frame restart.
module conv_controller_param #(
  parameter int KERNEL      = 3,
  parameter int SEL_W       = 2,
  parameter int CONV_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sample_load_en_i,
  input  logic             new_row_i,
  input  logic             coeff_load_en_i,
  output logic             modwait_o,
  output logic             sample_stream_o,
  output logic             sample_shift_o,
  output logic             convolve_en_o,
  output logic             coeff_ld_o,
  output logic [SEL_W-1:0] coeff_sel_o,
  output logic [SEL_W-1:0] col_cnt_o,
  output logic [CNT_W-1:0] conv_count_o,
  output logic             frame_done_o,
  output logic             coeff_err_o
);

  localparam int CYC_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CONV_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(KERNEL - 1);
  localparam logic [SEL_W-1:0] COL_FULL = SEL_W'(KERNEL);
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_COEFF_LD, S_FILL_LD, S_FILL_WAIT, S_CONV, S_STREAM_WAIT, S_STREAM_LD
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] coeff_sel_q, coeff_sel_d;
  logic [SEL_W-1:0] col_cnt_q, col_cnt_d;
  logic [CNT_W-1:0] conv_count_q, conv_count_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             frame_done_q, frame_done_d;
  logic             coeff_err_q, coeff_err_d;
  logic             enter_conv;

  always_comb begin
    state_d      = state_q;
    coeff_sel_d  = coeff_sel_q;
    col_cnt_d    = col_cnt_q;
    conv_count_d = conv_count_q;
    cyc_d        = cyc_q;
    frame_done_d = 1'b0;
    coeff_err_d  = coeff_load_en_i && (state_q != S_IDLE);
    enter_conv   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (coeff_load_en_i) begin
          state_d     = S_COEFF_LD;
          coeff_sel_d = '0;
        end else if (sample_load_en_i) begin
          state_d   = S_FILL_LD;
          col_cnt_d = SEL_ONE;
        end
      end
      S_COEFF_LD: begin
        if (coeff_sel_q == SEL_LAST) begin
          state_d     = S_IDLE;
          coeff_sel_d = '0;
        end else begin
          coeff_sel_d = coeff_sel_q + SEL_ONE;
        end
      end
      S_FILL_LD: begin
        if (col_cnt_q == COL_FULL) enter_conv = 1'b1;
        else                       state_d    = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (sample_load_en_i) begin
          state_d   = S_FILL_LD;
          col_cnt_d = col_cnt_q + SEL_ONE;
        end
      end
      S_CONV: begin
        if (cyc_q == CYC_LAST) begin
          if (new_row_i) begin
            state_d   = S_FILL_LD;
            col_cnt_d = SEL_ONE;
          end else begin
            state_d = S_STREAM_WAIT;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_STREAM_WAIT: begin
        if (sample_load_en_i && new_row_i) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end else if (new_row_i) begin
          state_d   = S_FILL_LD;
          col_cnt_d = SEL_ONE;
        end else if (sample_load_en_i) begin
          state_d = S_STREAM_LD;
        end
      end
      S_STREAM_LD: enter_conv = 1'b1;
      default:     state_d    = S_IDLE;
    endcase
    if (enter_conv) begin
      state_d = S_CONV;
      cyc_d   = '0;
      if (conv_count_q != {CNT_W{1'b1}}) conv_count_d = conv_count_q + CNT_W'(1);
    end
    // Counters belong to one frame; they are zero whenever the FSM sits in IDLE.
    if (state_d == S_IDLE) begin
      col_cnt_d    = '0;
      conv_count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      coeff_sel_q  <= '0;
      col_cnt_q    <= '0;
      conv_count_q <= '0;
      cyc_q        <= '0;
      frame_done_q <= 1'b0;
      coeff_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      coeff_sel_q  <= coeff_sel_d;
      col_cnt_q    <= col_cnt_d;
      conv_count_q <= conv_count_d;
      cyc_q        <= cyc_d;
      frame_done_q <= frame_done_d;
      coeff_err_q  <= coeff_err_d;
    end
  end

  always_comb begin
    modwait_o       = (state_q == S_COEFF_LD) || (state_q == S_FILL_LD) ||
                      (state_q == S_CONV) || (state_q == S_STREAM_LD);
    sample_stream_o = (state_q == S_CONV) || (state_q == S_STREAM_WAIT);
    sample_shift_o  = (state_q == S_FILL_LD) || (state_q == S_STREAM_LD);
    convolve_en_o   = (state_q == S_CONV);
    coeff_ld_o      = (state_q == S_COEFF_LD);
    coeff_sel_o     = coeff_sel_q;
    col_cnt_o       = col_cnt_q;
    conv_count_o    = conv_count_q;
    frame_done_o    = frame_done_q;
    coeff_err_o     = coeff_err_q;
  end

endmodule

// File: tb/tb_conv_controller_param.sv
// tb/tb_conv_controller_param.sv - bench for conv_controller_param
// Instance 0: KERNEL=3, CONV_CYCLES=1, CNT_W=2; instance 1: KERNEL=3, CONV_CYCLES=4, CNT_W=16.
module tb_conv_controller_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_v, sl_v, nr_v, cl_v;
  logic [1:0] mw_v, ss_v, sh_v, ce_v, cld_v, fd_v, err_v;
  logic [1:0][1:0] sel_v, col_v;
  logic [1:0]  cnt_a;
  logic [15:0] cnt_b;

  int checks = 0;
  int errors = 0;
  bit live = 0;

  conv_controller_param #(.KERNEL(3), .SEL_W(2), .CONV_CYCLES(1), .CNT_W(2)) dut_a (
    .clk_i(clk), .rst_i(rst_v[0]), .sample_load_en_i(sl_v[0]), .new_row_i(nr_v[0]),
    .coeff_load_en_i(cl_v[0]), .modwait_o(mw_v[0]), .sample_stream_o(ss_v[0]),
    .sample_shift_o(sh_v[0]), .convolve_en_o(ce_v[0]), .coeff_ld_o(cld_v[0]),
    .coeff_sel_o(sel_v[0]), .col_cnt_o(col_v[0]), .conv_count_o(cnt_a),
    .frame_done_o(fd_v[0]), .coeff_err_o(err_v[0]));

  conv_controller_param #(.KERNEL(3), .SEL_W(2), .CONV_CYCLES(4), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst_v[1]), .sample_load_en_i(sl_v[1]), .new_row_i(nr_v[1]),
    .coeff_load_en_i(cl_v[1]), .modwait_o(mw_v[1]), .sample_stream_o(ss_v[1]),
    .sample_shift_o(sh_v[1]), .convolve_en_o(ce_v[1]), .coeff_ld_o(cld_v[1]),
    .coeff_sel_o(sel_v[1]), .col_cnt_o(col_v[1]), .conv_count_o(cnt_b),
    .frame_done_o(fd_v[1]), .coeff_err_o(err_v[1]));

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: phase of the frame plus plain integer counters per instance.
  localparam int P_IDLE = 0, P_COEFF = 1, P_FILL = 2, P_FWAIT = 3, P_CONV = 4, P_SWAIT = 5, P_SLD = 6;
  int k_p[2]  = '{3, 3};
  int cc_p[2] = '{1, 4};
  int max_p[2] = '{3, 65535};
  int ph[2], cols[2], sel[2], left[2], cnt[2], fd[2], err[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_v[i]) begin
        ph[i] = P_IDLE; cols[i] = 0; sel[i] = 0; left[i] = 0; cnt[i] = 0; fd[i] = 0; err[i] = 0;
      end else begin
        err[i] = (cl_v[i] && ph[i] != P_IDLE) ? 1 : 0;
        fd[i] = 0;
        case (ph[i])
          P_IDLE: begin
            if (cl_v[i]) begin ph[i] = P_COEFF; sel[i] = 0; end
            else if (sl_v[i]) begin ph[i] = P_FILL; cols[i] = 1; end
          end
          P_COEFF: begin
            if (sel[i] == k_p[i] - 1) begin ph[i] = P_IDLE; sel[i] = 0; end
            else sel[i]++;
          end
          P_FILL: begin
            if (cols[i] == k_p[i]) begin
              ph[i] = P_CONV; left[i] = cc_p[i];
              cnt[i] = (cnt[i] < max_p[i]) ? cnt[i] + 1 : cnt[i];
            end else ph[i] = P_FWAIT;
          end
          P_FWAIT: if (sl_v[i]) begin ph[i] = P_FILL; cols[i]++; end
          P_CONV: begin
            if (left[i] == 1) begin
              if (nr_v[i]) begin ph[i] = P_FILL; cols[i] = 1; end
              else ph[i] = P_SWAIT;
            end else left[i]--;
          end
          P_SWAIT: begin
            if (sl_v[i] && nr_v[i]) begin ph[i] = P_IDLE; fd[i] = 1; cols[i] = 0; cnt[i] = 0; end
            else if (nr_v[i]) begin ph[i] = P_FILL; cols[i] = 1; end
            else if (sl_v[i]) ph[i] = P_SLD;
          end
          default: begin
            ph[i] = P_CONV; left[i] = cc_p[i];
            cnt[i] = (cnt[i] < max_p[i]) ? cnt[i] + 1 : cnt[i];
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      for (int i = 0; i < 2; i++) begin
        int p;
        p = ph[i];
        chk($sformatf("modwait%0d", i), int'(mw_v[i]),
            (p == P_COEFF || p == P_FILL || p == P_CONV || p == P_SLD) ? 1 : 0);
        chk($sformatf("stream%0d", i), int'(ss_v[i]), (p == P_CONV || p == P_SWAIT) ? 1 : 0);
        chk($sformatf("shift%0d", i), int'(sh_v[i]), (p == P_FILL || p == P_SLD) ? 1 : 0);
        chk($sformatf("conv_en%0d", i), int'(ce_v[i]), (p == P_CONV) ? 1 : 0);
        chk($sformatf("coeff_ld%0d", i), int'(cld_v[i]), (p == P_COEFF) ? 1 : 0);
        chk($sformatf("coeff_sel%0d", i), int'(sel_v[i]), sel[i]);
        chk($sformatf("col_cnt%0d", i), int'(col_v[i]), cols[i]);
        chk($sformatf("conv_count%0d", i), (i == 0) ? int'(cnt_a) : int'(cnt_b), cnt[i]);
        chk($sformatf("frame_done%0d", i), int'(fd_v[i]), fd[i]);
        chk($sformatf("coeff_err%0d", i), int'(err_v[i]), err[i]);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_v = 2'b11; sl_v = 2'b00; nr_v = 2'b00; cl_v = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_v = 2'b00;
    live = 1;
    // T1: reset state, held while inputs idle
    chk("t1_mw", int'(mw_v[0]), 0); chk("t1_cnt", int'(cnt_a), 0); chk("t1_col", int'(col_v[0]), 0);
    tick(); tick();
    chk("t1_hold_mw", int'(mw_v[0]), 0); chk("t1_hold_ss", int'(ss_v[0]), 0);
    // T2: coefficient load
    cl_v[0] = 1; tick(); cl_v[0] = 0;
    chk("t2_ld0", int'(cld_v[0]), 1); chk("t2_mw0", int'(mw_v[0]), 1); chk("t2_sel0", int'(sel_v[0]), 0);
    tick(); chk("t2_sel1", int'(sel_v[0]), 1);
    tick(); chk("t2_sel2", int'(sel_v[0]), 2); chk("t2_ld2", int'(cld_v[0]), 1);
    tick(); chk("t2_end_ld", int'(cld_v[0]), 0); chk("t2_end_mw", int'(mw_v[0]), 0);
    chk("t2_end_sel", int'(sel_v[0]), 0);
    // coeff load wins over sample load in IDLE
    cl_v[0] = 1; sl_v[0] = 1; tick(); cl_v[0] = 0; sl_v[0] = 0;
    chk("prio_ld", int'(cld_v[0]), 1); chk("prio_shift", int'(sh_v[0]), 0);
    tick(); tick(); tick();
    chk("prio_idle", int'(mw_v[0]), 0);
    // T3: column fill then single-cycle convolve
    sl_v[0] = 1;
    tick(); chk("t3_col1", int'(col_v[0]), 1); chk("t3_sh1", int'(sh_v[0]), 1);
    tick(); chk("t3_wait_sh", int'(sh_v[0]), 0); chk("t3_wait_mw", int'(mw_v[0]), 0);
    tick(); chk("t3_col2", int'(col_v[0]), 2);
    tick();
    tick(); chk("t3_col3", int'(col_v[0]), 3);
    sl_v[0] = 0;
    tick(); chk("t3_conv", int'(ce_v[0]), 1); chk("t3_cnt", int'(cnt_a), 1); chk("t3_ss", int'(ss_v[0]), 1);
    tick(); chk("t3_sw_ss", int'(ss_v[0]), 1); chk("t3_sw_ce", int'(ce_v[0]), 0);
    // stream loads until conv_count saturates at 3
    for (int n = 0; n < 4; n++) begin
      sl_v[0] = 1; tick(); sl_v[0] = 0;
      chk("sat_sld_shift", int'(sh_v[0]), 1);
      tick(); chk("sat_cnt", int'(cnt_a), (n + 2 > 3) ? 3 : n + 2);
      tick();
    end
    // T5: new_row restart then end of frame
    nr_v[0] = 1; tick(); nr_v[0] = 0;
    chk("t5_col", int'(col_v[0]), 1); chk("t5_sh", int'(sh_v[0]), 1); chk("t5_cnt", int'(cnt_a), 3);
    sl_v[0] = 1; repeat (4) tick(); sl_v[0] = 0;
    tick(); tick();
    sl_v[0] = 1; nr_v[0] = 1; tick(); sl_v[0] = 0; nr_v[0] = 0;
    chk("t5_fd", int'(fd_v[0]), 1); chk("t5_cnt0", int'(cnt_a), 0); chk("t5_ss", int'(ss_v[0]), 0);
    tick(); chk("t5_fd_off", int'(fd_v[0]), 0);
    // T6: protocol error in FILL_WAIT, then reset mid coefficient load
    sl_v[0] = 1; tick(); sl_v[0] = 0; tick();
    cl_v[0] = 1; tick(); cl_v[0] = 0;
    chk("t6_err", int'(err_v[0]), 1); chk("t6_col", int'(col_v[0]), 1); chk("t6_cld", int'(cld_v[0]), 0);
    tick(); chk("t6_err_off", int'(err_v[0]), 0);
    rst_v[0] = 1; tick(); rst_v[0] = 0;
    cl_v[0] = 1; tick(); tick(); cl_v[0] = 0;
    chk("t6_sel1", int'(sel_v[0]), 1); chk("t6_err_coeff", int'(err_v[0]), 1);
    rst_v[0] = 1; tick(); rst_v[0] = 0;
    chk("t6_rst_mw", int'(mw_v[0]), 0); chk("t6_rst_sel", int'(sel_v[0]), 0); chk("t6_rst_err", int'(err_v[0]), 0);
    tick();
    // T4: four-cycle convolve on instance 1
    sl_v[1] = 1; repeat (5) tick(); sl_v[1] = 0;
    for (int c = 0; c < 4; c++) begin
      tick(); chk("t4_fill_ce", int'(ce_v[1]), 1); chk("t4_fill_mw", int'(mw_v[1]), 1);
      chk("t4_fill_cnt", int'(cnt_b), 1);
    end
    tick(); chk("t4_sw_ce", int'(ce_v[1]), 0); chk("t4_sw_ss", int'(ss_v[1]), 1);
    for (int n = 0; n < 2; n++) begin
      sl_v[1] = 1; tick(); sl_v[1] = 0;
      for (int c = 0; c < 4; c++) begin
        tick(); chk("t4_ce", int'(ce_v[1]), 1); chk("t4_mw", int'(mw_v[1]), 1);
      end
      tick(); chk("t4_ce_off", int'(ce_v[1]), 0);
    end
    chk("t4_cnt3", int'(cnt_b), 3);
    // new_row on the last convolve cycle goes straight to a fresh fill
    sl_v[1] = 1; tick(); sl_v[1] = 0;
    repeat (4) tick();
    chk("nr_last_ce", int'(ce_v[1]), 1); chk("nr_cnt4", int'(cnt_b), 4);
    nr_v[1] = 1; tick(); nr_v[1] = 0;
    chk("nr_col1", int'(col_v[1]), 1); chk("nr_sh", int'(sh_v[1]), 1); chk("nr_ce", int'(ce_v[1]), 0);
    // reset mid convolve
    sl_v[1] = 1; repeat (4) tick(); sl_v[1] = 0;
    tick(); chk("rc_ce", int'(ce_v[1]), 1); chk("rc_cnt", int'(cnt_b), 5);
    rst_v[1] = 1; tick(); rst_v[1] = 0;
    chk("rc_ce0", int'(ce_v[1]), 0); chk("rc_cnt0", int'(cnt_b), 0); chk("rc_fd", int'(fd_v[1]), 0);
    chk("rc_col0", int'(col_v[1]), 0);
    tick(); tick();
    live = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
